// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles and publishes the count with a one-cycle valid pulse.
//
// Handshake: start is sampled only in IDLE and is otherwise ignored (no
// queuing). valid is a one-cycle pulse with no ready. The result is not
// back-pressured: freq_count/overflow simply hold until the next valid.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 25000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic [CNT_W-1:0] freq_count,
   output logic             valid,
   output logic             busy,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Last gate_cnt value of a window; 32-bit so windows up to 2^32-1 fit.
   localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q;
   state_t           state_d;

   logic             s1;
   logic             s2;
   logic             s3;
   logic             edge_det;

   logic [31:0]      gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_cnt_nxt;
   logic             ov_q;
   logic             ov_nxt;

   logic             clr_win;
   logic             gate_en;
   logic             load_res;

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 & ~s3;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      state_d  = state_q;
      clr_win  = 1'b0;
      gate_en  = 1'b0;
      load_res = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // cont alone never starts a measurement; only start does.
            if (start) begin
               state_d = ST_GATE;
               clr_win = 1'b1;
            end
         end
         ST_GATE: begin
            gate_en = 1'b1;
            if (gate_cnt == GATE_LAST) begin
               state_d  = ST_DONE;
               load_res = 1'b1;
            end
         end
         ST_DONE: begin
            // Edges seen in DONE are dropped; the next window starts clean.
            if (cont) begin
               state_d = ST_GATE;
               clr_win = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Saturating edge count including the current cycle's edge, so the last
   // gate cycle's edge is part of the value loaded into freq_count.
   always_comb begin
      edge_cnt_nxt = edge_cnt;
      ov_nxt       = ov_q;
      if (edge_det) begin
         if (edge_cnt == CNT_MAX) begin
            ov_nxt = 1'b1;
         end else begin
            edge_cnt_nxt = edge_cnt + CNT_ONE;
         end
      end
   end

   // Window counters: cleared when a window opens, advanced on gate cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         gate_cnt <= 32'd0;
         edge_cnt <= '0;
         ov_q     <= 1'b0;
      end else if (clr_win) begin
         gate_cnt <= 32'd0;
         edge_cnt <= '0;
         ov_q     <= 1'b0;
      end else if (gate_en) begin
         gate_cnt <= gate_cnt + 32'd1;
         edge_cnt <= edge_cnt_nxt;
         ov_q     <= ov_nxt;
      end
   end

   // Result registers: loaded on the last gate cycle, visible with valid in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_count <= '0;
         overflow   <= 1'b0;
         valid      <= 1'b0;
      end else begin
         valid <= load_res;
         if (load_res) begin
            freq_count <= edge_cnt_nxt;
            overflow   <= ov_nxt;
         end
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (10-cycle/8-bit and 30-cycle/2-bit
// windows) share one stimulus stream. A window-level model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_freq_meter;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       sig_in;
   logic       start;
   logic       cont;

   logic [7:0] freq0;
   logic       valid0;
   logic       busy0;
   logic       ov0;
   logic [1:0] dbg0;

   logic [1:0] freq1;
   logic       valid1;
   logic       busy1;
   logic       ov1;
   logic [1:0] dbg1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(10), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
      .freq_count(freq0), .valid(valid0), .busy(busy0), .overflow(ov0),
      .dbg_state(dbg0)
   );

   freq_meter #(.GATE_CYCLES(30), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
      .freq_count(freq1), .valid(valid1), .busy(busy1), .overflow(ov1),
      .dbg_state(dbg1)
   );

   // ---------------- behavioural model ----------------
   // Per instance: a window opens on the clock edge that accepts start; the
   // next g_len edges are gate edges, the one after is the DONE edge.
   int unsigned g_len [2] = '{10, 30};
   int unsigned c_max [2] = '{255, 3};

   bit   live = 1'b0;
   logic sig_hist[$] = '{1'b0, 1'b0, 1'b0};   // [0]=previous sample, [1], [2] older

   bit m_active [2];
   int m_pos    [2];
   int m_cnt    [2];
   bit m_ov     [2];
   int m_freq   [2];
   bit m_fov    [2];
   bit m_valid  [2];

   task automatic model_step(input int i, input logic e);
      m_valid[i] = 1'b0;
      if (m_active[i]) begin
         m_pos[i]++;
         if (m_pos[i] <= int'(g_len[i])) begin
            if (e) begin
               if (m_cnt[i] == int'(c_max[i])) m_ov[i] = 1'b1;
               else m_cnt[i]++;
            end
            if (m_pos[i] == int'(g_len[i])) begin
               m_freq[i]  = m_cnt[i];
               m_fov[i]   = m_ov[i];
               m_valid[i] = 1'b1;
            end
         end else if (cont) begin
            m_pos[i] = 0;
            m_cnt[i] = 0;
            m_ov[i]  = 1'b0;
         end else begin
            m_active[i] = 1'b0;
         end
      end else if (start) begin
         m_active[i] = 1'b1;
         m_pos[i]    = 0;
         m_cnt[i]    = 0;
         m_ov[i]     = 1'b0;
      end
   endtask

   // Model advances on each clock edge from the inputs sampled at that edge.
   always @(posedge clk) begin
      logic e;
      if (rst) begin
         live     = 1'b1;
         sig_hist = '{1'b0, 1'b0, 1'b0};
         for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_pos[i]    = 0;
            m_cnt[i]    = 0;
            m_ov[i]     = 1'b0;
            m_freq[i]   = 0;
            m_fov[i]    = 1'b0;
            m_valid[i]  = 1'b0;
         end
      end else begin
         // An input rise is seen two sampled edges later, once it is synchronised.
         e = sig_hist[1] & ~sig_hist[2];
         sig_hist.push_front(sig_in);
         void'(sig_hist.pop_back());
         for (int i = 0; i < 2; i++) model_step(i, e);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input string tag, input int i, input logic [31:0] f,
                           input logic v, input logic b, input logic o, input logic [1:0] d);
      chk({tag, ".freq_count"}, f, 32'(m_freq[i]));
      chk({tag, ".valid"}, 32'(v), 32'(m_valid[i]));
      chk({tag, ".busy"}, 32'(b), 32'(m_active[i]));
      chk({tag, ".overflow"}, 32'(o), 32'(m_fov[i]));
      chk({tag, ".idle_state"}, 32'(d == 2'd0), 32'(!m_active[i]));
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (live) begin
         cmp_inst("u0", 0, {24'd0, freq0}, valid0, busy0, ov0, dbg0);
         cmp_inst("u1", 1, {30'd0, freq1}, valid1, busy1, ov1, dbg1);
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge and are sampled at the next rising edge.
   task automatic drive(input logic r, input logic s, input logic st, input logic c);
      @(negedge clk);
      rst    = r;
      sig_in = s;
      start  = st;
      cont   = c;
   endtask

   task automatic idle_gap(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // 2-high/2-low pulse train whose first high sample is at rel=-1, so the
   // synchronised edges land on gate edges 1, 5, 9, ...
   function automatic logic pulse(input int rel, input int last);
      return (rel >= -1) && (rel <= last) && (((rel + 1) % 4) < 2);
   endfunction

   // ---------------- stimulus ----------------
   // In each scenario, step rel sets the inputs sampled at edge T+rel; checks
   // made at step rel see the outputs after edge T+rel-1.
   initial begin
      logic s_v;
      logic c_v;
      rst    = 1'b1;
      sig_in = 1'b0;
      start  = 1'b0;
      cont   = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state holds with no start.
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         chk("rst_freq", {24'd0, freq0}, 32'd0);
         chk("rst_valid", 32'(valid0), 32'd0);
         chk("rst_busy", 32'(busy0), 32'd0);
         chk("rst_overflow", 32'(ov0), 32'd0);
      end

      // Basic count: three edges in one 10-cycle window.
      for (int rel = -1; rel <= 13; rel++) begin
         drive(1'b0, pulse(rel, 8), rel == 0, 1'b0);
         if (rel >= 1 && rel <= 11) chk("basic_busy", 32'(busy0), 32'd1);
         if (rel == 11) begin
            chk("basic_valid", 32'(valid0), 32'd1);
            chk("basic_freq", {24'd0, freq0}, 32'd3);
            chk("basic_overflow", 32'(ov0), 32'd0);
         end
         if (rel == 12) chk("basic_idle", 32'(busy0), 32'd0);
      end
      idle_gap(40);

      // Overflow: five edges into the 2-bit, 30-cycle instance.
      for (int rel = -1; rel <= 33; rel++) begin
         drive(1'b0, pulse(rel, 16), rel == 0, 1'b0);
         if (rel == 11) chk("ovf_u0_freq", {24'd0, freq0}, 32'd3);
         if (rel == 31) begin
            chk("ovf_valid", 32'(valid1), 32'd1);
            chk("ovf_freq", {30'd0, freq1}, 32'd3);
            chk("ovf_flag", 32'(ov1), 32'd1);
         end
      end
      idle_gap(40);

      // Mid-window reset: two edges counted, then reset aborts the window.
      for (int rel = -1; rel <= 22; rel++) begin
         drive(rel == 6, pulse(rel, 4), rel == 0, 1'b0);
         if (rel == 7) begin
            chk("abort_busy", 32'(busy0), 32'd0);
            chk("abort_freq", {24'd0, freq0}, 32'd0);
         end
         if (rel >= 7) chk("abort_no_valid", 32'(valid0), 32'd0);
      end
      idle_gap(40);

      // Window boundary: edge on the last gate edge counts, one later does not.
      for (int run = 0; run < 2; run++) begin
         for (int rel = -1; rel <= 13; rel++) begin
            drive(1'b0, rel == 8 + run, rel == 0, 1'b0);
            if (rel == 11) begin
               chk("edge_valid", 32'(valid0), 32'd1);
               chk(run == 0 ? "edge_last_gate" : "edge_in_done",
                   {24'd0, freq0}, run == 0 ? 32'd1 : 32'd0);
            end
         end
         idle_gap(40);
      end

      // Continuous mode with ignored extra starts.
      for (int rel = 0; rel <= 40; rel++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), rel == 0 || rel == 4 || rel == 11, rel < 30);
         if (rel == 11 || rel == 22 || rel == 33) chk("cont_valid", 32'(valid0), 32'd1);
         if (rel == 12 || rel == 21 || rel == 32) chk("cont_no_valid", 32'(valid0), 32'd0);
         if (rel == 34) chk("cont_idle", 32'(busy0), 32'd0);
      end
      idle_gap(40);

      // Randomised traffic: bursty input, random start/cont, rare resets.
      s_v = 1'b0;
      c_v = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 2) == 0) s_v = ~s_v;
         if ($urandom_range(0, 29) == 0) c_v = ~c_v;
         drive($urandom_range(0, 199) == 0, s_v, $urandom_range(0, 7) == 0, c_v);
      end
      idle_gap(40);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
